inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
- Circular instruction buffer (IB) between fetch stage IF1 and decode.
- Accepts 0-4 packed fetch entries per cycle from IF1 and reports its occupancy so IF1 can decide whether to push.
- Presents up to 2 oldest entries per cycle to decode; decode pops 0-2 per cycle.
- Flush on redirect empties it in one cycle.

Parameters:
- IB_WIDTH_LOG2, 4, log2 of depth (`IB_WIDTH_LOG2 in define.vh).
- IB_DEPTH, 16, entry count = 2**IB_WIDTH_LOG2.
- IB_DATA_BUS_WD, 66, entry width {pc_valid, pc_is_jump, pc[31:0], inst[31:0]} (`IB_DATA_BUS_WD).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_IB  in  1  synchronous clear; shares its source with flush_IF.
- if1_to_ib  in  4*IB_DATA_BUS_WD  packed push entries; slot k at [(k+1)*WD-1:k*WD], slot 0 is oldest.
- push_num  in  3  number of valid slots, 0-4; slots 0..push_num-1 are written.
- can_push_size  out  IB_WIDTH_LOG2+1  current occupancy count. IF1 pushes only if bit IB_WIDTH_LOG2 of (count+push_num) is 0.
- ib_to_id  out  2*IB_DATA_BUS_WD  oldest two entries; slot 0 is the head.
- ib_valid  out  2  per-slot valid: slot0 = count>=1, slot1 = count>=2.
- pop_num  in  2  entries consumed by decode this cycle, 0-2.
- ib_overflow  out  1  sticky error: a push exceeded free space.

Behaviour:
- State: storage array [IB_DEPTH], head pointer, tail pointer (IB_WIDTH_LOG2 bits each, natural wrap mod IB_DEPTH), count register (IB_WIDTH_LOG2+1 bits).
- Reset (rst_n=0, async): head=tail=count=0, ib_overflow=0, ib_valid=0, can_push_size=0. Storage contents are not reset.
- Push acceptance: push_ok = (count + push_num <= IB_DEPTH-1), evaluated on the current (pre-pop) count.
  - Pops in the same cycle do not widen the window. This matches IF1's check.
  - Effective capacity is IB_DEPTH-1 (15); one slot always stays free.
- If push_ok: slot k goes to storage[tail+k] for k<push_num; tail += push_num.
- If not push_ok and push_num!=0: the whole push is dropped (no partial writes) and ib_overflow is set. ib_overflow clears only on reset.
- Pop: eff_pop = min(pop_num, count). head += eff_pop. Popping beyond occupancy is clamped, never errors.
- count_next = count + (push_ok ? push_num : 0) - eff_pop. Push and pop happen in the same cycle.
- Outputs: ib_to_id slot j = storage[head+j] (combinational read of registered state). ib_valid derives from the registered count.
  - A pushed entry becomes visible on the cycle after the push edge (1-cycle latency). There is no push-to-pop bypass.
  - can_push_size = count (registered).
- Flush: flush_IB=1 at an edge sets head=tail=count=0 and ignores that cycle's push and pop. Flush has priority over all other events. ib_overflow is not cleared by flush.
- Wrap-around: a 4-entry push at tail=14 writes indices 14, 15, 0, 1. Head reads wrap the same way.
- Entries are stored verbatim; pc_valid=0 entries occupy slots and are filtered downstream.
- An async reset assertion mid-push or mid-pop discards everything immediately.

Decomposition:
- define.vh holds IB_WIDTH_LOG2, IB_DATA_BUS_WD and the entry field offsets (PC_VALID, PC_IS_JUMP, PC, INST) used by IF1, IB and decode.
- Single module. A small combinational sub-block, ib_ptr_add (pointer + offset mod depth), is optional; inline is fine.

Test Plan:
1. Reset, then push_num=4 of PCs 0x1c000000..0x1c00000c with pop_num=0 → next cycle can_push_size=4, ib_valid=2'b11, slot0 pc=0x1c000000, slot1 pc=0x1c000004.
2. Fill to count=12, then push_num=4 → rejected (12+4=16); count stays 12, ib_overflow=1. Then push_num=3 at count=12 → accepted, count=15.
3. Count=2, push_num=2 and pop_num=2 in the same cycle → count=2, head advances 2, outputs show the newly pushed pair.
4. Wrap: head=tail=14, count=0, push 4 entries A-D; pop 2 per cycle → order A,B then C,D; tail=2, final count=0.
5. Count=1, pop_num=2 → clamped; count=0, ib_valid=0, no underflow.
6. Count=7, flush_IB=1 together with push_num=3 → next cycle count=0, ib_valid=0, the push is lost; ib_overflow unchanged. Drop rst_n async mid-cycle → outputs zero before the next clock edge.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: shared instruction-buffer sizing, entry field offsets and pointer helper
package inst_buffer_pkg;
  localparam int IB_WIDTH_LOG2  = 4;
  localparam int IB_DEPTH       = 1 << IB_WIDTH_LOG2;
  localparam int IB_DATA_BUS_WD = 66;
  localparam int INST           = 0;
  localparam int PC             = 32;
  localparam int PC_IS_JUMP     = 64;
  localparam int PC_VALID       = 65;
  function automatic logic [IB_WIDTH_LOG2-1:0] ib_ptr_add(input logic [IB_WIDTH_LOG2-1:0] ptr, input logic [2:0] off);
    return ptr + IB_WIDTH_LOG2'(off);
  endfunction
endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: circular fetch-to-decode buffer, 4-wide push, 2-wide pop, one-cycle flush
module inst_buffer
  import inst_buffer_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_IB,
  input  logic [4*IB_DATA_BUS_WD-1:0]     if1_to_ib,
  input  logic [2:0]                      push_num,
  output logic [IB_WIDTH_LOG2:0]          can_push_size,
  output logic [2*IB_DATA_BUS_WD-1:0]     ib_to_id,
  output logic [1:0]                      ib_valid,
  input  logic [1:0]                      pop_num,
  output logic                            ib_overflow
);
  logic [IB_DATA_BUS_WD-1:0] mem [IB_DEPTH];
  logic [IB_WIDTH_LOG2-1:0]  head, tail;
  logic [IB_WIDTH_LOG2:0]    count, count_next;
  logic [1:0]                eff_pop;
  logic                      push_ok;
  // acceptance uses the pre-pop count so a same-cycle pop never widens the window
  always_comb begin
    push_ok    = ({1'b0, count} + 6'(push_num)) <= 6'(IB_DEPTH - 1);
    eff_pop    = ({3'b0, pop_num} > count) ? count[1:0] : pop_num;
    count_next = count + (push_ok ? 5'(push_num) : 5'd0) - 5'(eff_pop);
  end
  // storage is written only for accepted pushes and is never reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (!flush_IB && push_ok && 3'(k) < push_num)
        mem[ib_ptr_add(tail, 3'(k))] <= if1_to_ib[k*IB_DATA_BUS_WD +: IB_DATA_BUS_WD];
  end
  // pointers, occupancy and sticky overflow; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ib_overflow <= 1'b0;
    end else if (flush_IB) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= ib_ptr_add(head, {1'b0, eff_pop});
      tail  <= push_ok ? ib_ptr_add(tail, push_num) : tail;
      count <= count_next;
      if (!push_ok && push_num != 3'd0) ib_overflow <= 1'b1;
    end
  end
  // oldest two entries and their valids come straight from registered state
  always_comb begin
    ib_to_id      = {mem[ib_ptr_add(head, 3'd1)], mem[head]};
    ib_valid      = {count >= 5'd2, count != 5'd0};
    can_push_size = count;
  end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: scoreboard bench for the instruction buffer
module tb_inst_buffer;
  import inst_buffer_pkg::*;
  typedef logic [IB_DATA_BUS_WD-1:0] entry_t;
  logic                        clk = 0;
  logic                        rst_n = 0;
  logic                        flush_IB = 0;
  logic [4*IB_DATA_BUS_WD-1:0] if1_to_ib = '0;
  logic [2:0]                  push_num = 0;
  logic [IB_WIDTH_LOG2:0]      can_push_size;
  logic [2*IB_DATA_BUS_WD-1:0] ib_to_id;
  logic [1:0]                  ib_valid;
  logic [1:0]                  pop_num = 0;
  logic                        ib_overflow;
  int total = 0, bad = 0;
  entry_t sb[$];
  entry_t slot_data[4];
  logic m_ovf = 0;
  logic [31:0] next_pc = 32'h1c000000;

  inst_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush_IB(flush_IB), .if1_to_ib(if1_to_ib),
    .push_num(push_num), .can_push_size(can_push_size), .ib_to_id(ib_to_id),
    .ib_valid(ib_valid), .pop_num(pop_num), .ib_overflow(ib_overflow)
  );

  always #5 clk = ~clk;

  function automatic entry_t mk(input logic v, input logic [31:0] pc);
    return {v, pc[2], pc, ~pc};
  endfunction

  function automatic entry_t slot(input int j);
    return ib_to_id[j*IB_DATA_BUS_WD +: IB_DATA_BUS_WD];
  endfunction

  task automatic load(input int n);
    for (int k = 0; k < 4; k++) begin
      slot_data[k] = mk(1'b1, next_pc);
      if (k < n) next_pc += 4;
    end
  endtask

  task automatic cycle(input int pn, input int pp, input bit fl);
    int eff;
    bit ok;
    push_num = 3'(pn);
    pop_num  = 2'(pp);
    flush_IB = fl;
    for (int k = 0; k < 4; k++) if1_to_ib[k*IB_DATA_BUS_WD +: IB_DATA_BUS_WD] = slot_data[k];
    ok = sb.size() + pn <= IB_DEPTH - 1;
    if (fl) sb.delete();
    else begin
      eff = pp < sb.size() ? pp : sb.size();
      repeat (eff) void'(sb.pop_front());
      if (ok) for (int k = 0; k < pn; k++) sb.push_back(slot_data[k]);
      else if (pn != 0) m_ovf = 1;
    end
    @(posedge clk);
    #1;
    push_num = 0;
    pop_num  = 0;
    flush_IB = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    sb.delete();
    m_ovf = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (can_push_size !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", can_push_size); end
    total++; if (ib_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", ib_valid); end
    total++; if (ib_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ib_overflow); end
  endtask

  task automatic test_push4();
    load(4);
    cycle(4, 0, 0);
    total++; if (can_push_size !== 5'd4) begin bad++; $display("FAIL push4_count got=%0d exp=4", can_push_size); end
    total++; if (ib_valid !== 2'b11) begin bad++; $display("FAIL push4_valid got=%b exp=11", ib_valid); end
    total++; if (slot(0)[PC +: 32] !== 32'h1c000000) begin bad++; $display("FAIL push4_pc0 got=%h exp=1c000000", slot(0)[PC +: 32]); end
    total++; if (slot(1)[PC +: 32] !== 32'h1c000004) begin bad++; $display("FAIL push4_pc1 got=%h exp=1c000004", slot(1)[PC +: 32]); end
    total++; if (slot(0) !== sb[0]) begin bad++; $display("FAIL push4_entry0 got=%h exp=%h", slot(0), sb[0]); end
  endtask

  task automatic test_overflow();
    repeat (2) begin load(4); cycle(4, 0, 0); end
    total++; if (can_push_size !== 5'd12) begin bad++; $display("FAIL fill_count got=%0d exp=12", can_push_size); end
    load(0);
    cycle(4, 0, 0);
    total++; if (can_push_size !== 5'd12) begin bad++; $display("FAIL ovf_count got=%0d exp=12", can_push_size); end
    total++; if (ib_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ib_overflow); end
    load(3);
    cycle(3, 0, 0);
    total++; if (can_push_size !== 5'd15) begin bad++; $display("FAIL push3_count got=%0d exp=15", can_push_size); end
    total++; if (int'(can_push_size) !== sb.size()) begin bad++; $display("FAIL push3_model got=%0d exp=%0d", can_push_size, sb.size()); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      total++; if (slot(0) !== sb[0]) begin bad++; $display("FAIL drain_s0_%0d got=%h exp=%h", i, slot(0), sb[0]); end
      if (sb.size() >= 2) begin
        total++; if (slot(1) !== sb[1]) begin bad++; $display("FAIL drain_s1_%0d got=%h exp=%h", i, slot(1), sb[1]); end
      end
      cycle(0, 2, 0);
    end
    total++; if (can_push_size !== 5'd0 || ib_valid !== 2'b00) begin bad++; $display("FAIL drain_empty got=%0d/%b exp=0/00", can_push_size, ib_valid); end
  endtask

  task automatic test_push_pop();
    entry_t first_new;
    load(2);
    cycle(2, 0, 0);
    load(2);
    first_new = slot_data[0];
    total++; if (slot(0) !== sb[0]) begin bad++; $display("FAIL pp_before got=%h exp=%h", slot(0), sb[0]); end
    cycle(2, 2, 0);
    total++; if (can_push_size !== 5'd2) begin bad++; $display("FAIL pp_count got=%0d exp=2", can_push_size); end
    total++; if (slot(0) !== first_new) begin bad++; $display("FAIL pp_new0 got=%h exp=%h", slot(0), first_new); end
    total++; if (slot(1) !== sb[1]) begin bad++; $display("FAIL pp_new1 got=%h exp=%h", slot(1), sb[1]); end
  endtask

  task automatic test_clamp();
    cycle(0, 1, 0);
    total++; if (can_push_size !== 5'd1 || ib_valid !== 2'b01) begin bad++; $display("FAIL clamp_one got=%0d/%b exp=1/01", can_push_size, ib_valid); end
    cycle(0, 2, 0);
    total++; if (can_push_size !== 5'd0) begin bad++; $display("FAIL clamp_count got=%0d exp=0", can_push_size); end
    total++; if (ib_valid !== 2'b00) begin bad++; $display("FAIL clamp_valid got=%b exp=00", ib_valid); end
  endtask

  task automatic test_flush();
    load(4); cycle(4, 0, 0);
    load(3); cycle(3, 0, 0);
    total++; if (can_push_size !== 5'd7) begin bad++; $display("FAIL preflush_count got=%0d exp=7", can_push_size); end
    load(3);
    cycle(3, 0, 1);
    total++; if (can_push_size !== 5'd0 || ib_valid !== 2'b00) begin bad++; $display("FAIL flush_empty got=%0d/%b exp=0/00", can_push_size, ib_valid); end
    total++; if (ib_overflow !== m_ovf) begin bad++; $display("FAIL flush_ovf got=%b exp=%b", ib_overflow, m_ovf); end
    load(2);
    cycle(2, 0, 0);
    total++; if (slot(0) !== sb[0]) begin bad++; $display("FAIL postflush_head got=%h exp=%h", slot(0), sb[0]); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 0;
    sb.delete();
    m_ovf = 0;
    #1;
    total++; if (can_push_size !== 5'd0 || ib_valid !== 2'b00 || ib_overflow !== 1'b0) begin bad++; $display("FAIL async_rst got=%0d/%b/%b exp=0/00/0", can_push_size, ib_valid, ib_overflow); end
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
  endtask

  task automatic test_wrap();
    entry_t a, b, c, d, e;
    do_reset();
    repeat (7) begin load(2); cycle(2, 0, 0); end
    repeat (7) cycle(0, 2, 0);
    total++; if (can_push_size !== 5'd0) begin bad++; $display("FAIL wrap_start got=%0d exp=0", can_push_size); end
    a = mk(1'b1, 32'h2000_0000); b = mk(1'b0, 32'h2000_0004);
    c = mk(1'b1, 32'h2000_0008); d = mk(1'b1, 32'h2000_000c);
    slot_data[0] = a; slot_data[1] = b; slot_data[2] = c; slot_data[3] = d;
    cycle(4, 0, 0);
    total++; if (slot(0) !== a || slot(1) !== b) begin bad++; $display("FAIL wrap_ab got=%h_%h exp=%h_%h", slot(0), slot(1), a, b); end
    cycle(0, 2, 0);
    total++; if (slot(0) !== c || slot(1) !== d) begin bad++; $display("FAIL wrap_cd got=%h_%h exp=%h_%h", slot(0), slot(1), c, d); end
    cycle(0, 2, 0);
    total++; if (can_push_size !== 5'd0 || ib_valid !== 2'b00) begin bad++; $display("FAIL wrap_end got=%0d/%b exp=0/00", can_push_size, ib_valid); end
    e = mk(1'b1, 32'h2000_0010);
    slot_data[0] = e;
    cycle(1, 0, 0);
    total++; if (slot(0) !== e) begin bad++; $display("FAIL wrap_tail got=%h exp=%h", slot(0), e); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_push4();
        test_overflow();
        test_drain();
        test_push_pop();
        test_clamp();
        test_flush();
        test_async_reset();
        test_wrap();
      end
      begin
        #100000;
        total++; bad++;
        $display("FAIL watchdog got=timeout exp=done");
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
